// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed to hold any w-bit unsigned value: ceil(w*log10(2)).
    // 0.30103 is scaled to integers so this stays a constant function.
    function automatic int digits_for_width(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Legal BCD inputs 5..9 map to 8..12, so the 4-bit add never wraps.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative binary-to-BCD converter, one bit per clock; BIN2BCD_SIGNED_EN adds signed input and neg output
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
`ifdef BIN2BCD_SIGNED_EN
    output logic                        neg,
`endif
    output logic                        overflow
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 2 || BIN_W > 32 || DIGITS < 1 || DIGITS > digits_for_width(32)) begin : g_param_check
        $error("bin2bcd_seq: BIN_W must be 2..32 and DIGITS 1..10");
    end

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   sreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_sticky;
    logic [BIN_W-1:0]   bin_load;

`ifdef BIN2BCD_SIGNED_EN
    logic               neg_pend;

    // Magnitude of the two's-complement operand; the most negative value
    // wraps to 2^(BIN_W-1), which is exactly right as an unsigned number.
    always_comb begin
        bin_load = bin;
        if (bin[BIN_W-1]) begin
            bin_load = (~bin) + BIN_W'(1);
        end
    end
`else
    assign bin_load = bin;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start only matters in IDLE; the last shift is when the counter is at 1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, shift-add-3, and publish the result with a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_pend   <= 1'b0;
            neg        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg       <= bin_load;
                        acc        <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                        neg_pend   <= bin[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    // A bit leaving the top digit is a carry of 10^DIGITS.
                    acc        <= {acc_adj[ACC_W-2:0], sreg[BIN_W-1]};
                    sreg       <= {sreg[BIN_W-2:0], 1'b0};
                    ovf_sticky <= ovf_sticky | acc_adj[ACC_W-1];
                    cnt        <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bcd      <= acc;
                    overflow <= ovf_sticky;
                    done     <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                    neg      <= neg_pend;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq against an arithmetic reference
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SIGNED_EN
    localparam int BW = 8;
    localparam int DA = 3;
    localparam int DB = 2;
`else
    localparam int BW = 16;
    localparam int DA = 5;
    localparam int DB = 3;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_a = 1'b0;
    logic            start_b = 1'b0;
    logic [BW-1:0]   bin_a = '0;
    logic [BW-1:0]   bin_b = '0;
    logic            busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [4*DA-1:0] bcd_a;
    logic [4*DB-1:0] bcd_b;
`ifdef BIN2BCD_SIGNED_EN
    logic            neg_a, neg_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(DA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a),
`ifdef BIN2BCD_SIGNED_EN
        .neg(neg_a),
`endif
        .overflow(ovf_a)
    );

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(DB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b),
`ifdef BIN2BCD_SIGNED_EN
        .neg(neg_b),
`endif
        .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int d);
        longint unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Numeric magnitude of the operand as the converter should interpret it.
    function automatic longint unsigned ref_mag(input logic [BW-1:0] v);
        longint unsigned m = 64'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[BW-1]) m = (64'd1 << BW) - m;
`endif
        return m;
    endfunction

    // Decimal digits of the magnitude, keeping only the low d digits.
    function automatic logic [63:0] ref_bcd(input longint unsigned m, input int d);
        longint unsigned v = m % pow10(d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r = r | (64'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic drive(input bit sel, input bit s, input logic [BW-1:0] v);
        if (sel) begin start_b = s; bin_b = v; end
        else     begin start_a = s; bin_a = v; end
    endtask

    task automatic check_result(input bit sel, input logic [BW-1:0] value, input string tag);
        longint unsigned m = ref_mag(value);
        int d = sel ? DB : DA;
        chk({tag, "_bcd"}, sel ? 64'(bcd_b) : 64'(bcd_a), ref_bcd(m, d));
        chk({tag, "_ovf"}, 64'(sel ? ovf_b : ovf_a), 64'(m >= pow10(d)));
`ifdef BIN2BCD_SIGNED_EN
        chk({tag, "_neg"}, 64'(sel ? neg_b : neg_a), 64'(value[BW-1] && m != 0));
`endif
    endtask

    // One conversion: checks latency, busy length, result, and that done is a single pulse.
    // With disturb set, start toggles and bin changes while the conversion runs.
    task automatic conv(input bit sel, input logic [BW-1:0] value, input bit disturb, input string tag);
        int lat = 0;
        int busy_n = 0;
        @(negedge clk);
        drive(sel, 1'b1, value);
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                lat = k;
                break;
            end
            if (sel ? busy_b : busy_a) busy_n++;
            if (!disturb || k >= BW + 1) drive(sel, 1'b0, BW'($urandom));
            else drive(sel, k[0], BW'($urandom));
        end
        drive(sel, 1'b0, sel ? bin_b : bin_a);
        chk({tag, "_latency"}, 64'(lat), 64'(BW + 2));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(BW + 1));
        check_result(sel, value, tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(sel ? done_b : done_a), 64'd0);
        chk({tag, "_idle"}, 64'(sel ? busy_b : busy_a), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] v;
        int ndone;
        int per;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
        chk("rst_done", 64'({done_a, done_b}), 64'd0);
        chk("rst_bcd", 64'({bcd_a, bcd_b}), 64'd0);
        chk("rst_ovf", 64'({ovf_a, ovf_b}), 64'd0);
        rst = 1'b0;

`ifdef BIN2BCD_SIGNED_EN
        conv(0, 8'h80, 0, "min_neg");
        conv(0, 8'hFF, 0, "minus1");
        conv(0, 8'h00, 0, "zero");
        conv(0, 8'h7F, 0, "max_pos");
        conv(1, 8'h80, 0, "b_min_ovf");
        conv(1, 8'd99, 0, "b_99");
        conv(1, 8'hD8, 0, "b_m40");
        conv(0, 8'd100, 1, "disturb");
`else
        conv(0, 16'hFFFF, 0, "max");
        conv(0, 16'd0, 0, "zero");
        conv(0, 16'd1234, 0, "v1234");
        conv(1, 16'd1000, 0, "b_1000_ovf");
        conv(1, 16'd999, 0, "b_999");
        conv(1, 16'hFFFF, 0, "b_max_ovf");
        conv(0, 16'd500, 1, "disturb");
`endif

        for (int i = 0; i < 12; i++) conv(0, BW'($urandom), 0, "rand_a");
        for (int i = 0; i < 8; i++)  conv(1, BW'($urandom), 0, "rand_b");

        // Start held high: one done every BW+2 cycles, each with the same result.
        v = BW'($urandom);
        ndone = 0;
        per = BW + 2;
        @(negedge clk);
        drive(0, 1'b1, v);
        @(posedge clk);
        for (int k = 1; k <= 3 * per; k++) begin
            @(negedge clk);
            if (done_a) begin
                ndone++;
                chk("b2b_spacing", 64'(k), 64'(ndone * per));
                check_result(0, v, "b2b");
            end
            if (k == 3 * per) drive(0, 1'b0, v);
        end
        chk("b2b_count", 64'(ndone), 64'd3);
        repeat (2) @(negedge clk);

        // Reset during the 8th shift cycle discards the conversion.
        conv(0, BW'(77), 0, "pre_rst");
        @(negedge clk);
`ifdef BIN2BCD_SIGNED_EN
        drive(0, 1'b1, 8'd121);
`else
        drive(0, 1'b1, 16'd4321);
`endif
        @(posedge clk);
        repeat (8) @(negedge clk);
        drive(0, 1'b0, bin_a);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_bcd", 64'(bcd_a), 64'd0);
        chk("midrst_ovf", 64'(ovf_a), 64'd0);
        ndone = 0;
        for (int k = 0; k < 3 * per; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        conv(0, BW'(42), 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
